// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and state encoding for the RV32M multiply/divide unit
package muldiv_pkg;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  localparam int DIV_ITERS = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/muldiv_unit_div.sv
// div_restoring_core: unsigned restoring divider, one quotient bit per step
module div_restoring_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  localparam int CW = $clog2(DIV_ITERS);
  logic [31:0] quo, rem, dsr;
  logic [CW-1:0] cnt;
  logic [32:0] diff;
  // quotient/remainder expose this step's result so the last step can be captured directly
  always_comb begin
    diff      = {rem, quo[31]} - {1'b0, dsr};
    quotient  = {quo[30:0], ~diff[32]};
    remainder = diff[32] ? {rem[30:0], quo[31]} : diff[31:0];
    done      = cnt == '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
      cnt <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
      cnt <= CW'(DIV_ITERS - 1);
    end else if (step) begin
      quo <= quotient;
      rem <= remainder;
      cnt <= cnt - CW'(1);
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M execution unit (single-cycle multiply, 32-step divide)
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            muldiv_busy,
  output logic            muldiv_ready,
  output logic [XLEN-1:0] result
);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  state_t state, nxt;
  logic [2:0] f3;
  logic [XLEN-1:0] a, b, a_mag, b_mag, spec_res, quotient, remainder, q_fix, r_fix, mul_res, div_res;
  logic [2*XLEN-1:0] prod;
  logic accept, in_signed, special, div_done;
  assign accept    = state == IDLE && start && !kill;
  assign in_signed = !funct3[0];
  assign special   = funct3[2] && (op_b == '0 || (in_signed && op_a == MIN_NEG && op_b == '1));
  assign spec_res  = op_b == '0 ? (funct3[1] ? op_a : DIV_BY_ZERO_Q) : (funct3[1] ? '0 : MIN_NEG);
  assign a_mag     = in_signed && op_a[XLEN-1] ? -op_a : op_a;
  assign b_mag     = in_signed && op_b[XLEN-1] ? -op_b : op_b;
  div_restoring_core u_core (
    .clk,
    .rst,
    .load     (accept),
    .step     (state == DIV && !kill),
    .dividend (a_mag),
    .divisor  (b_mag),
    .done     (div_done),
    .quotient,
    .remainder
  );
  // operands are sign-extended to 2*XLEN so one unsigned multiply covers all four variants
  always_comb begin
    prod    = {{XLEN{f3 != F3_MULHU && a[XLEN-1]}}, a} * {{XLEN{f3 == F3_MULH && b[XLEN-1]}}, b};
    mul_res = f3 == F3_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    q_fix   = !f3[0] && (a[XLEN-1] ^ b[XLEN-1]) ? -quotient : quotient;
    r_fix   = !f3[0] && a[XLEN-1] ? -remainder : remainder;
    div_res = f3[1] ? r_fix : q_fix;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = kill ? IDLE :
          state == IDLE ? (!start ? IDLE : !funct3[2] ? MUL : special ? DONE : DIV) :
          state == MUL ? DONE :
          state == DIV ? (div_done ? DONE : DIV) : IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      f3     <= '0;
      a      <= '0;
      b      <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        f3 <= funct3;
        a  <= op_a;
        b  <= op_b;
      end
      if (accept && special) result <= spec_res;
      else if (!kill && state == MUL) result <= mul_res;
      else if (!kill && state == DIV && div_done) result <= div_res;
    end
  always_comb begin
    muldiv_busy  = state == MUL || state == DIV;
    muldiv_ready = state == DONE;
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed table, corner sequences and randomized ops against an arithmetic model
module tb_muldiv_unit;
  logic clk = 0, rst = 0, start = 0, kill = 0;
  logic [2:0] funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0, result;
  logic muldiv_busy, muldiv_ready;
  int errors = 0, checks = 0;

  muldiv_unit dut (
    .clk, .rst, .start, .kill, .funct3, .op_a, .op_b,
    .muldiv_busy, .muldiv_ready, .result
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    p  = 0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      default: begin
        if (b == 0) return f[1] ? a : 32'hFFFFFFFF;
        if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f[1] ? 32'h0 : 32'h80000000;
        case (f)
          3'd4: return 32'(ia / ib);
          3'd5: return a / b;
          3'd6: return 32'(ia % ib);
          default: return a % b;
        endcase
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 2;
    if (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
    return 33;
  endfunction

  // Issues one op, then scrambles the operand inputs; returns latency and result at ready
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output int busy_bad);
    @(negedge clk);
    start = 1; funct3 = f; op_a = a; op_b = b;
    @(posedge clk);
    #1 start = 0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
    lat = 0; res = 'x; busy_bad = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (muldiv_ready) begin
        lat = k; res = result;
        if (muldiv_busy) busy_bad++;
        break;
      end
      if (!muldiv_busy) busy_bad++;
    end
    @(negedge clk);
    if (muldiv_ready) busy_bad++;
  endtask

  vec_t vecs[$];
  int lat, bb, pulses;
  logic [31:0] res, r1, r2;

  initial begin
    vecs = '{
      '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2},
      '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2},
      '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2},
      '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 2},
      '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33},
      '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33},
      '{3'd5, 32'd100,      32'd7,        32'd14,       33},
      '{3'd7, 32'd100,      32'd7,        32'd2,        33},
      '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1},
      '{3'd6, 32'd5,        32'd0,        32'd5,        1},
      '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
      '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1},
      '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33},
      '{3'd4, 32'd0,        32'd0,        32'hFFFFFFFF, 1}
    };
    #12;
    chk("reset_busy", {31'b0, muldiv_busy}, 32'd0);
    chk("reset_ready", {31'b0, muldiv_ready}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1;

    foreach (vecs[i]) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, lat, res, bb);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_busy", i), 32'(bb), 32'd0);
    end

    // kill mid-divide: no pulse, result retained, next MUL fine
    do_op(3'd0, 32'd6, 32'd7, lat, res, bb);
    chk("pre_kill_mul", res, 32'd42);
    @(negedge clk);
    start = 1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk);
    #1 start = 0;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (muldiv_ready) pulses++;
      if (k == 10) kill = 1;
    end
    @(posedge clk);
    #1 kill = 0;
    @(negedge clk);
    if (muldiv_ready) pulses++;
    chk("kill_no_ready", 32'(pulses), 32'd0);
    chk("kill_busy_low", {31'b0, muldiv_busy}, 32'd0);
    chk("kill_result_kept", result, 32'd42);
    do_op(3'd0, 32'd11, 32'd13, lat, res, bb);
    chk("after_kill_mul", res, 32'd143);
    chk("after_kill_lat", 32'(lat), 32'd2);

    // start held through DONE, then a second MUL issues on the next IDLE cycle
    @(negedge clk);
    start = 1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5;
    pulses = 0; r1 = '0; r2 = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (muldiv_ready) begin
        pulses++;
        if (pulses == 1) r1 = result; else r2 = result;
      end
      if (k == 3) begin op_a = 32'd4; op_b = 32'd9; end
      if (k == 5) start = 0;
    end
    chk("held_pulses", 32'(pulses), 32'd2);
    chk("held_first", r1, 32'd15);
    chk("held_second", r2, 32'd36);

    // randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      do_op(f, a, b, lat, res, bb);
      chk($sformatf("rnd%0d_f%0d_%h_%h", i, f, a, b), res, ref_res(f, a, b));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(ref_lat(f, a, b)));
      chk($sformatf("rnd%0d_busy", i), 32'(bb), 32'd0);
    end

    // reset mid-divide clears outputs immediately
    @(negedge clk);
    start = 1; funct3 = 3'd5; op_a = 32'hDEADBEEF; op_b = 32'd7;
    @(posedge clk);
    #1 start = 0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", {31'b0, muldiv_busy}, 32'd1);
    rst = 0;
    #1;
    chk("rst_busy", {31'b0, muldiv_busy}, 32'd0);
    chk("rst_ready", {31'b0, muldiv_ready}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1;
    do_op(3'd4, 32'hFFFFFF9C, 32'd7, lat, res, bb);
    chk("post_rst_div", res, 32'hFFFFFFF2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
